// File: rtl/mx_pkg.sv
// Shared FP32/MX definitions for the FP32-to-MX (E5M2) conversion path.
// Field positions use data-sheet numbering: bit 32 is the sign and bit 1 is the mantissa LSB.
package mx_pkg;

    localparam int MX_BLOCK_SIZE = 32;

    localparam int EXP_MSB = 31;
    localparam int EXP_LSB = 24;
    localparam int MAN_MSB = 23;
    localparam int MAN_LSB = 1;

    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    typedef logic [30:0] fp32_mag_t;

    // Bit N in data-sheet numbering is vector index N-1.
    function automatic fp32_mag_t fp32_mag(input logic [31:0] d);
        return d[EXP_MSB-1:MAN_LSB-1];
    endfunction

    function automatic logic fp32_is_nan(input logic [31:0] d);
        return (d[EXP_MSB-1:EXP_LSB-1] == EXP_ALL_ONES) && (d[MAN_MSB-1:MAN_LSB-1] != '0);
    endfunction

endpackage

// File: rtl/mx_block_amax_max2.sv
// Two-input unsigned magnitude max with NaN flag merge (combinational).
// Unsigned order puts NaN above Inf above all finite values, so NaN propagates for free.
module mx_mag_max2
    import mx_pkg::*;
(
    input  fp32_mag_t a,
    input  fp32_mag_t b,
    input  logic      a_nan,
    input  logic      b_nan,
    output fp32_mag_t max_mag,
    output logic      max_nan
);

    assign max_mag = (b > a) ? b : a;
    assign max_nan = a_nan | b_nan;

endmodule

// File: rtl/mx_block_amax.sv
// Per-block running max magnitude feeding the E8M0 shared-scale divider; double-buffered output.
// Optional early block close (in_last / out_partial) under `define MX_AMAX_FLUSH_EN.
module mx_block_amax
    import mx_pkg::*;
#(
    parameter int BLOCK_SIZE = MX_BLOCK_SIZE,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
`ifdef MX_AMAX_FLUSH_EN
    input  logic        in_last,
    output logic        out_partial,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] out_amax,
    output logic        out_nan
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);

    logic [CNT_W-1:0] count;
    fp32_mag_t        acc;
    logic             acc_nan;

    fp32_mag_t elem_mag;
    logic      elem_nan;
    fp32_mag_t max_mag;
    logic      max_nan;
    fp32_mag_t merged_mag;
    logic      merged_nan;
    logic      at_last;
    logic      closing;
    logic      xfer;
    logic      unused_sign;

    assign elem_mag    = fp32_mag(in_data);
    assign elem_nan    = fp32_is_nan(in_data);
    assign unused_sign = in_data[31];

    mx_mag_max2 u_max2 (
        .a       (acc),
        .b       (elem_mag),
        .a_nan   (acc_nan),
        .b_nan   (elem_nan),
        .max_mag (max_mag),
        .max_nan (max_nan)
    );

    // The first element of a block must not see the previous block's accumulator.
    assign merged_mag = (count == '0) ? elem_mag : max_mag;
    assign merged_nan = (count == '0) ? elem_nan : max_nan;

    assign at_last = (count == LAST_IDX);
`ifdef MX_AMAX_FLUSH_EN
    assign closing = at_last | in_last;
`else
    assign closing = at_last;
`endif

    // Only the closing element can stall, and only when the output slot will not free this cycle.
    assign in_ready = !(closing && out_valid && !out_ready);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            acc     <= '0;
            acc_nan <= 1'b0;
        end else if (xfer) begin
            acc     <= merged_mag;
            acc_nan <= merged_nan;
            count   <= closing ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_amax  <= '0;
            out_nan   <= 1'b0;
        end else if (xfer && closing) begin
            out_valid <= 1'b1;
            out_amax  <= merged_mag;
            out_nan   <= merged_nan;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MX_AMAX_FLUSH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_partial <= 1'b0;
        end else if (xfer && closing) begin
            out_partial <= !at_last;
        end
    end
`endif

endmodule

// File: doc/mx_block_amax.md
Name: mx_block_amax

Overview:
- Streaming stage directly upstream of the E8M0 shared-scale divider in the FP32-to-MX (E5M2) path.
- Accepts FP32 elements one per cycle over a valid/ready handshake and tracks the running maximum magnitude of each BLOCK_SIZE-element block.
- At block end it presents the 31-bit magnitude (exponent plus mantissa, sign stripped) on a held valid/ready output. This output is exactly the divider's 31-bit input.
- Double-buffered: accumulation of the next block overlaps with a pending, unconsumed result.

Parameters:
- BLOCK_SIZE, 32, elements per MX block; integer, 2 or more.
- CNT_W, 5, element counter width; equals ceil(log2(BLOCK_SIZE)).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  32  FP32 element; bit 32 is the sign, bits 31:24 the exponent, bits 23:1 the mantissa.
- out_valid  output  1  block result is valid.
- out_ready  input  1  downstream accepts the result.
- out_amax  output  31  maximum of in_data[31:1] over the block.
- out_nan  output  1  at least one element of the block was NaN (exponent 255, mantissa nonzero).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - count=0, acc=0, acc_nan=0.
  - out_valid=0, out_amax=0, out_nan=0.
- Input transfer occurs when in_valid and in_ready are both 1.
- Magnitude compare: unsigned compare of in_data[31:1] against acc.
  - Under this ordering Inf beats every finite value and NaN beats Inf, so NaN propagates with no extra logic.
  - Sign bit ignored.
  - Zero and denormal inputs compare normally.
- First element of a block (count==0): acc loads in_data[31:1] unconditionally, without comparing against the stale acc.
- Later elements: acc = max(acc, in_data[31:1]).
- acc_nan ORs in the NaN detect of each element; it is cleared when the first element of a block loads.
- count increments per transfer and wraps to 0 after BLOCK_SIZE-1.
- Last element (count==BLOCK_SIZE-1):
  - The next edge loads out_amax = max(acc, element) and out_nan = acc_nan OR element-NaN, and sets out_valid=1.
  - Latency: result valid 1 cycle after the last element transfers.
- Output hold: out_amax and out_nan stay stable while out_valid=1 and out_ready=0.
- out_valid clears on the edge where out_valid and out_ready are both 1, unless a new result loads on that same edge; in that case out_valid stays 1 with the new data.
- in_ready = NOT (count==BLOCK_SIZE-1 AND out_valid AND NOT out_ready).
  - Only the closing element of a block stalls on a full output register; all other elements always accept.
  - This is a combinational path from out_ready to in_ready.
- in_valid=0 cycles: no state change (bubbles allowed mid-block).
- Simultaneous pop of the old result and push of a new one: the new result is written and out_valid stays 1.
- Reset mid-block discards the partial block and any pending result.

Optional Feature:
- Macro: MX_AMAX_FLUSH_EN.
- Defined:
  - Adds input in_last (1 bit), sampled with the transfer.
  - in_last=1 closes the block early: the result is published exactly as at count==BLOCK_SIZE-1, and count returns to 0.
  - in_ready applies the stall rule when in_last=1 OR count==BLOCK_SIZE-1.
  - Adds output out_partial (1 bit): 1 if the published block had fewer than BLOCK_SIZE elements; reset value 0.
- Not defined: no in_last or out_partial ports; blocks are always exactly BLOCK_SIZE elements.

Decomposition:
- Shared package mx_pkg:
  - FP32 field constants: EXP_MSB=31, EXP_LSB=24, MAN_MSB=23, MAN_LSB=1.
  - EXP_ALL_ONES=8'hFF.
  - MX_BLOCK_SIZE=32.
  - typedef fp32_mag_t (31 bits).
- Sub-module mx_mag_max2:
  - Combinational two-input unsigned max with NaN flag out.
  - Reused later by a tree-reduction variant.

Test Plan:
- 32 elements 0x3F800000 (1.0) except element 7 = 0xC0400000 (-3.0) -> out_amax=0x40400000 (sign stripped), out_nan=0, out_valid 1 cycle after the 32nd transfer.
- One element 0x7F800000 (+Inf), rest 0x42000000 -> out_amax=0x7F800000, out_nan=0. Divider check: scale 0xFE.
- One element 0x7FC00001 (NaN) plus one 0xFF800000 (-Inf) -> out_amax=0x7FC00001, out_nan=1.
- Two back-to-back blocks with out_ready=0 -> block 2's 32nd element sees in_ready=0. Raise out_ready -> block 1's result pops and block 2's result loads on the same edge, with no gap in out_valid.
- Bubbles (in_valid toggling) with all elements 0x00000001 (denormal), then rst_n low at element 20 -> outputs and count return to 0 asynchronously. The next full block yields 0x00000001.
- With MX_AMAX_FLUSH_EN: in_last on element 4 of {1.0, 2.0, 0.5, 8.0, 4.0} -> out_amax=0x41000000, out_partial=1, count returns to 0.
